// File: rtl/msg_schedule.sv
// SHA-2 message-schedule expander: loads a 16-word block, then streams W[0..ROUNDS-1].
// Optional abort input is enabled by defining MSG_SCHED_ABORT_EN.
module msg_schedule #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [6:0]        out_idx,
`ifdef MSG_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic              out_last
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        load_cnt;
  logic [6:0]        t;
  logic [WORD_W-1:0] win [16];
  logic [WORD_W-1:0] new_word;
  logic              kill;
  logic              in_fire;
  logic              out_fire;

`ifdef MSG_SCHED_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Handshake protocol: a word moves on a rising edge where valid && ready are
  // both high; abort (when present) cancels any handshake on that edge.
  assign in_fire  = (state == LOAD) && in_valid && !kill;
  assign out_fire = (state == EMIT) && out_ready && !kill;

  // Next schedule word, written into the slot vacated by the shift.
  assign new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD: if (in_fire && load_cnt == 4'd15) state_next = EMIT;
      EMIT: if (out_fire && t == LAST_T)      state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == EMIT);
    out_data  = win[0];
    out_idx   = t;
    out_last  = (state == EMIT) && (t == LAST_T);
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      state    <= LOAD;
      load_cnt <= 4'd0;
      t        <= 7'd0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state <= state_next;
      if (in_fire) begin
        win[load_cnt] <= in_data;
        // wraps to 0 after the 16th word, ready for the next block
        load_cnt      <= load_cnt + 4'd1;
        t             <= 7'd0;
      end
      if (out_fire) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= new_word;
        t       <= (t == LAST_T) ? 7'd0 : t + 7'd1;
      end
    end
  end

endmodule
